// File: rtl/return_addr_stack.sv
// Return-address stack: classifies JAL/JALR by link-register usage, pushes
// PC+4 on calls, pops on returns, and predicts the return target from the
// current top of stack with zero latency.
module return_addr_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       Flush,
    input  logic                       InstrValid,
    input  logic [6:0]                 Op,
    input  logic [4:0]                 Rd,
    input  logic [4:0]                 Rs1,
    input  logic [WIDTH-1:0]           PCPlus4,
    output logic [WIDTH-1:0]           RetTarget,
    output logic                       RetValid,
    output logic [$clog2(DEPTH+1)-1:0] Count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    logic [WIDTH-1:0] entry [DEPTH];
    logic [PW-1:0]    top;
    logic [PW-1:0]    top_m1;

    logic is_jal;
    logic is_jalr;
    logic rd_link;
    logic rs1_link;
    logic push_only;
    logic pop_only;
    logic pop_push;
    logic empty;
    logic full;

    // Instruction classification. x1 and x5 are the link registers.
    assign is_jal   = (Op == OP_JAL);
    assign is_jalr  = (Op == OP_JALR);
    assign rd_link  = (Rd == 5'd1) || (Rd == 5'd5);
    assign rs1_link = (Rs1 == 5'd1) || (Rs1 == 5'd5);

    // A JALR linking through both registers with the same index is a plain call;
    // with different indices it is a coroutine swap (replace top).
    assign push_only = InstrValid &&
                       ((is_jal && rd_link) ||
                        (is_jalr && rd_link && !(rs1_link && (Rd != Rs1))));
    assign pop_only  = InstrValid && is_jalr && !rd_link && rs1_link;
    assign pop_push  = InstrValid && is_jalr && rd_link && rs1_link && (Rd != Rs1);

    assign empty  = (Count == '0);
    assign full   = (Count == CW'(DEPTH));
    // DEPTH is a power of two, so natural pointer wrap gives modulo DEPTH.
    assign top_m1 = top - 1'b1;

    // Zero-latency prediction from the registered stack state.
    assign RetTarget = empty ? '0 : entry[top_m1];
    assign RetValid  = (pop_only || pop_push) && !empty;

    // Stack state update; priority is rst, then Flush, then call/return actions.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the entries are cleared on reset so RetTarget never exposes
            // stale data from before reset; this is cheap at this depth.
            for (int i = 0; i < DEPTH; i++) begin
                entry[i] <= '0;
            end
            // NOTE: non-blocking assignments keep every register update in this
            // block reading the pre-edge values, so ordering here does not matter.
            top   <= '0;
            Count <= '0;
        end else if (Flush) begin
            // Only the bookkeeping is cleared; stale entries are unreachable.
            top   <= '0;
            Count <= '0;
        end else if (push_only || (pop_push && empty)) begin
            // A full stack overwrites its oldest entry by wrapping the pointer.
            entry[top] <= PCPlus4;
            top        <= top + 1'b1;
            if (!full) begin
                Count <= Count + 1'b1;
            end
        end else if (pop_push) begin
            entry[top_m1] <= PCPlus4;
        end else if (pop_only && !empty) begin
            top   <= top_m1;
            Count <= Count - 1'b1;
        end
    end

endmodule

// File: tb/tb_return_addr_stack.sv
// Self-checking bench for return_addr_stack: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// queue-based reference model of the return-address stack.
module tb_return_addr_stack;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;

    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_ADD  = 7'b0110011;

    logic             clk;
    logic             rst;
    logic             Flush;
    logic             InstrValid;
    logic [6:0]       Op;
    logic [4:0]       Rd;
    logic [4:0]       Rs1;
    logic [WIDTH-1:0] PCPlus4;
    logic [WIDTH-1:0] RetTarget;
    logic             RetValid;
    logic [3:0]       Count;

    int checks = 0;
    int fails  = 0;

    // Reference model: newest address at the back of the queue.
    logic [WIDTH-1:0] model_q[$];
    bit               model_ready = 0;

    return_addr_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .Flush      (Flush),
        .InstrValid (InstrValid),
        .Op         (Op),
        .Rd         (Rd),
        .Rs1        (Rs1),
        .PCPlus4    (PCPlus4),
        .RetTarget  (RetTarget),
        .RetValid   (RetValid),
        .Count      (Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    function automatic bit is_return(input logic v, input logic [6:0] op,
                                     input logic [4:0] rd, input logic [4:0] rs1);
        return v && (op == OP_JALR) && is_link(rs1) && (!is_link(rd) || (rd != rs1));
    endfunction

    function automatic void model_push(input logic [WIDTH-1:0] a);
        model_q.push_back(a);
        if (model_q.size() > DEPTH) void'(model_q.pop_front());
    endfunction

    // Reference model update at every rising edge.
    always @(posedge clk) begin
        if (rst) begin
            model_q.delete();
            model_ready = 1;
        end else if (Flush) begin
            model_q.delete();
        end else if (InstrValid && Op == OP_JAL) begin
            if (is_link(Rd)) model_push(PCPlus4);
        end else if (InstrValid && Op == OP_JALR) begin
            if (is_link(Rd) && is_link(Rs1) && Rd != Rs1) begin
                if (model_q.size() == 0) model_push(PCPlus4);
                else model_q[model_q.size()-1] = PCPlus4;
            end else if (is_link(Rd)) begin
                model_push(PCPlus4);
            end else if (is_link(Rs1)) begin
                if (model_q.size() > 0) void'(model_q.pop_back());
            end
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (model_ready) begin
            logic [WIDTH-1:0] exp_t;
            exp_t = (model_q.size() > 0) ? model_q[model_q.size()-1] : '0;
            check("model_count", 64'(Count), 64'(model_q.size()));
            check("model_target", 64'(RetTarget), 64'(exp_t));
            check("model_valid", 64'(RetValid),
                  64'(is_return(InstrValid, Op, Rd, Rs1) && model_q.size() > 0));
        end
    end

    task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [WIDTH-1:0] pc);
        InstrValid = v;
        Op         = op;
        Rd         = rd;
        Rs1        = rs1;
        PCPlus4    = pc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, OP_ADD, 5'd0, 5'd0, '0);
    endtask

    task automatic call(input logic [WIDTH-1:0] pc);
        drive(1'b1, OP_JAL, 5'd1, 5'd0, pc);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        Flush = 1'b0;
        idle();

        // 1. Reset held two cycles.
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("reset_count", 64'(Count), 64'd0);
        check("reset_target", 64'(RetTarget), 64'd0);
        check("reset_valid", 64'(RetValid), 64'd0);

        // 2. Nested calls and returns.
        call(32'h104);
        call(32'h208);
        call(32'h30C);
        for (int k = 0; k < 3; k++) begin
            logic [WIDTH-1:0] exp_a;
            case (k)
                0: exp_a = 32'h30C;
                1: exp_a = 32'h208;
                default: exp_a = 32'h104;
            endcase
            drive(1'b1, OP_JALR, 5'd0, 5'd1, '0);
            #1;
            check("nest_target", 64'(RetTarget), 64'(exp_a));
            check("nest_valid", 64'(RetValid), 64'd1);
            tick();
        end
        drive(1'b1, OP_JALR, 5'd0, 5'd1, '0);
        #1;
        check("nest_empty_valid", 64'(RetValid), 64'd0);
        check("nest_empty_target", 64'(RetTarget), 64'd0);
        check("nest_empty_count", 64'(Count), 64'd0);
        tick();

        // 3. Overflow: nine pushes into eight entries.
        for (int i = 1; i <= 9; i++) call(WIDTH'(32'h10 * i));
        idle();
        #1;
        check("ovf_count", 64'(Count), 64'd8);
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, OP_JALR, 5'd0, 5'd5, '0);
            #1;
            check("ovf_pop_target", 64'(RetTarget), 64'(32'h10 * (9 - k)));
            tick();
        end
        idle();
        #1;
        check("ovf_drained", 64'(Count), 64'd0);

        // 4. Coroutine swap.
        call(32'h40);
        drive(1'b1, OP_JALR, 5'd1, 5'd5, 32'h88);
        #1;
        check("swap_target_now", 64'(RetTarget), 64'h40);
        check("swap_valid_now", 64'(RetValid), 64'd1);
        tick();
        idle();
        #1;
        check("swap_target_next", 64'(RetTarget), 64'h88);
        check("swap_count_next", 64'(Count), 64'd1);

        // 5. Non-link and gating cases.
        drive(1'b1, OP_JAL, 5'd0, 5'd0, 32'h500);
        tick();
        check("jal_x0_count", 64'(Count), 64'd1);
        drive(1'b1, OP_JALR, 5'd1, 5'd1, 32'h504);
        tick();
        check("jalr_same_link_count", 64'(Count), 64'd2);
        check("jalr_same_link_target", 64'(RetTarget), 64'h504);
        drive(1'b0, OP_JAL, 5'd1, 5'd0, 32'h508);
        tick();
        check("invalid_count", 64'(Count), 64'd2);

        // 6. Flush with a simultaneous call.
        call(32'h600);
        check("pre_flush_count", 64'(Count), 64'd3);
        Flush = 1'b1;
        drive(1'b1, OP_JAL, 5'd1, 5'd0, 32'h700);
        tick();
        Flush = 1'b0;
        drive(1'b1, OP_JALR, 5'd0, 5'd1, '0);
        #1;
        check("flush_count", 64'(Count), 64'd0);
        check("flush_valid", 64'(RetValid), 64'd0);
        check("flush_target", 64'(RetTarget), 64'd0);
        tick();

        // Reset asserted mid-sequence, alongside a call.
        call(32'h800);
        call(32'h804);
        rst = 1'b1;
        drive(1'b1, OP_JAL, 5'd5, 5'd0, 32'h808);
        tick();
        rst = 1'b0;
        idle();
        #1;
        check("midreset_count", 64'(Count), 64'd0);
        check("midreset_target", 64'(RetTarget), 64'd0);

        // Randomized traffic, checked every cycle by the model comparison.
        for (int n = 0; n < 3000; n++) begin
            logic [6:0] op;
            logic [4:0] rd;
            logic [4:0] rs1;
            int sel;
            sel = $urandom_range(0, 9);
            op  = (sel < 4) ? OP_JAL : (sel < 9) ? OP_JALR : 7'($urandom);
            sel = $urandom_range(0, 3);
            rd  = (sel == 0) ? 5'd0 : (sel == 1) ? 5'd1 : (sel == 2) ? 5'd5 : 5'($urandom);
            sel = $urandom_range(0, 3);
            rs1 = (sel == 0) ? 5'd0 : (sel == 1) ? 5'd1 : (sel == 2) ? 5'd5 : 5'($urandom);
            drive(($urandom_range(0, 99) < 85), op, rd, rs1, $urandom);
            Flush = ($urandom_range(0, 99) < 3);
            rst   = ($urandom_range(0, 199) < 1);
            tick();
        end
        rst = 1'b0;
        Flush = 1'b0;
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
